// File: rtl/cpu_pkg.sv
// Shared definitions for the PC/fetch sequencer: state encoding, opcode constants, defaults.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } seq_state_e;

    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEF     = 4;
    localparam int unsigned MEM_TIMEOUT_DEF = 16;

    // Major opcodes seen by decode; the sequencer itself only consumes is_halt.
    localparam logic [6:0] OPC_JAL   = 7'b110_1111;
    localparam logic [6:0] OPC_JALR  = 7'b110_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_HALT  = 7'b111_1111;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC select (sequential step vs resolved jump target) and return-address generation.
module next_pc_mux #(
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic [31:0] pc_i,
    input  logic        valid_jump_i,
    input  logic [31:0] jump_target_i,
    output logic [31:0] next_pc_o,
    output logic [31:0] link_addr_o
);

    logic [31:0] seq_pc;

    // Sequential flow wraps modulo 2^32 by construction.
    assign seq_pc      = pc_i + PC_STEP;
    assign link_addr_o = seq_pc;
    assign next_pc_o   = valid_jump_i ? jump_target_i : seq_pc;

endmodule

// File: rtl/pc_sequencer.sv
// PC register and FETCH -> EXEC -> UPDATE sequencer with imem handshake and fetch timeout.
// Optional build macro PC_ALIGN_CHECK_EN faults on a taken jump to a non word-aligned target.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter int unsigned PC_STEP     = PC_STEP_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        valid_jump,
    input  logic [31:0] jump_target,
    input  logic        is_link,
    input  logic        is_halt,
    output logic [31:0] link_addr,
    output logic        link_we,
    output logic [31:0] pc,
    output logic        halted,
    output logic        fault
);

    localparam int unsigned   TW      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(MEM_TIMEOUT - 1);

    seq_state_e state_q, state_d;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic          instr_valid_q, instr_valid_d;
    logic          link_we_q, link_we_d;
    logic [31:0]   link_addr_q, link_addr_d;
    logic          fault_q, fault_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    logic [31:0] next_pc_w;
    logic [31:0] link_addr_w;
    logic        timeout_hit;
    logic        misalign;

    next_pc_mux #(
        .PC_STEP (32'(PC_STEP))
    ) u_next_pc_mux (
        .pc_i          (pc_q),
        .valid_jump_i  (valid_jump),
        .jump_target_i (jump_target),
        .next_pc_o     (next_pc_w),
        .link_addr_o   (link_addr_w)
    );

`ifdef PC_ALIGN_CHECK_EN
    assign misalign = valid_jump && (jump_target[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Down-counter reloads outside FETCH; an ack on the terminal cycle still wins.
    assign timeout_hit = (state_q == ST_FETCH) && !imem_ack && (to_cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALT, ST_FAULT: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack)         state_d = ST_EXEC;
                else if (timeout_hit) state_d = ST_FAULT;
            end
            ST_EXEC: begin
                if (exec_done) begin
                    if (is_halt)       state_d = ST_HALT;
                    else if (misalign) state_d = ST_FAULT;
                    else               state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state_q == ST_FETCH);
        halted   = (state_q == ST_HALT);
    end

    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        link_we_d     = 1'b0;
        link_addr_d   = link_addr_q;
        fault_d       = fault_q;
        to_cnt_d      = (state_q == ST_FETCH) ? to_cnt_q - 1'b1 : TO_LOAD;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) pc_d = RESET_PC;
            end
            ST_FAULT: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    fault_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d       = imem_data;
                    instr_valid_d = 1'b1;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                end
            end
            ST_EXEC: begin
                if (exec_done && !is_halt) begin
                    if (misalign) begin
                        fault_d = 1'b1;
                    end else begin
                        pc_d = next_pc_w;
                        if (is_link && valid_jump) begin
                            link_we_d   = 1'b1;
                            link_addr_d = link_addr_w;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            link_we_q     <= 1'b0;
            link_addr_q   <= '0;
            fault_q       <= 1'b0;
            to_cnt_q      <= TO_LOAD;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            link_we_q     <= link_we_d;
            link_addr_q   <= link_addr_d;
            fault_q       <= fault_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign link_we     = link_we_q;
    assign link_addr   = link_addr_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expectations are hand-computed. Honors PC_ALIGN_CHECK_EN.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        valid_jump;
    logic [31:0] jump_target;
    logic        is_link;
    logic        is_halt;
    logic [31:0] link_addr;
    logic        link_we;
    logic [31:0] pc;
    logic        halted;
    logic        fault;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .valid_jump  (valid_jump),
        .jump_target (jump_target),
        .is_link     (is_link),
        .is_halt     (is_halt),
        .link_addr   (link_addr),
        .link_we     (link_we),
        .pc          (pc),
        .halted      (halted),
        .fault       (fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic fetch_ack(input logic [31:0] data);
        imem_ack  = 1'b1;
        imem_data = data;
        step();
        imem_ack  = 1'b0;
    endtask

    task automatic exec(input logic vj, input logic [31:0] tgt, input logic lnk, input logic hlt);
        exec_done   = 1'b1;
        valid_jump  = vj;
        jump_target = tgt;
        is_link     = lnk;
        is_halt     = hlt;
        step();
        exec_done   = 1'b0;
        valid_jump  = 1'b0;
        is_link     = 1'b0;
        is_halt     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = '0;
        exec_done = 1'b0; valid_jump = 1'b0; jump_target = '0; is_link = 1'b0; is_halt = 1'b0;
        step(); step();
        check("rst_pc", pc, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_ivalid", {31'b0, instr_valid}, 32'h0);
        check("rst_linkwe", {31'b0, link_we}, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        rst_n = 1'b1;
        step();
        check("idle_req", {31'b0, imem_req}, 32'h0);

        pulse_start();
        check("f0_req", {31'b0, imem_req}, 32'h1);
        check("f0_addr", imem_addr, 32'h0);
        step(); step();
        check("f0_req_held", {31'b0, imem_req}, 32'h1);
        check("f0_addr_stable", imem_addr, 32'h0);
        fetch_ack(32'hDEAD_0001);
        check("e0_ivalid", {31'b0, instr_valid}, 32'h1);
        check("e0_instr", instr, 32'hDEAD_0001);
        check("e0_pc", pc, 32'h0);
        check("e0_req", {31'b0, imem_req}, 32'h0);
        fetch_ack(32'h1234_5678);
        check("e0_ivalid_pulse", {31'b0, instr_valid}, 32'h0);
        check("e0_ack_ignored", instr, 32'hDEAD_0001);

        exec(1'b1, 32'h10, 1'b0, 1'b0);
        check("j10_req", {31'b0, imem_req}, 32'h1);
        check("j10_addr", imem_addr, 32'h10);
        check("j10_nolink", {31'b0, link_we}, 32'h0);
        fetch_ack(32'h0000_0013);
        exec(1'b0, 32'h0, 1'b0, 1'b0);
        check("seq_addr", imem_addr, 32'h14);

        fetch_ack(32'h0000_006F);
        exec(1'b1, 32'h40, 1'b1, 1'b0);
        check("jal_pc", pc, 32'h40);
        check("jal_linkwe", {31'b0, link_we}, 32'h1);
        check("jal_linkaddr", link_addr, 32'h18);
        exec(1'b1, 32'h99, 1'b1, 1'b0);
        check("stray_exec_linkwe", {31'b0, link_we}, 32'h0);
        check("stray_exec_addr", imem_addr, 32'h40);
        pulse_start();
        check("start_in_fetch", imem_addr, 32'h40);
        check("start_in_fetch_req", {31'b0, imem_req}, 32'h1);

        fetch_ack(32'hFFFF_FFFF);
        exec(1'b1, 32'h80, 1'b0, 1'b1);
        check("halt_halted", {31'b0, halted}, 32'h1);
        check("halt_pc", pc, 32'h40);
        check("halt_req", {31'b0, imem_req}, 32'h0);
        step();
        check("halt_stays", {31'b0, halted}, 32'h1);
        pulse_start();
        check("restart_halted", {31'b0, halted}, 32'h0);
        check("restart_addr", imem_addr, 32'h0);
        check("restart_req", {31'b0, imem_req}, 32'h1);

        for (int i = 0; i < 15; i++) step();
        check("to_15_fault", {31'b0, fault}, 32'h0);
        check("to_15_req", {31'b0, imem_req}, 32'h1);
        step();
        check("to_16_fault", {31'b0, fault}, 32'h1);
        check("to_16_req", {31'b0, imem_req}, 32'h0);
        step(); step();
        check("fault_sticky", {31'b0, fault}, 32'h1);
        pulse_start();
        check("fault_clear", {31'b0, fault}, 32'h0);
        check("fault_restart_addr", imem_addr, 32'h0);

        fetch_ack(32'h0000_0013);
        exec(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        fetch_ack(32'h0000_0013);
        exec(1'b0, 32'h0, 1'b1, 1'b0);
        check("wrap_pc", pc, 32'h0);
        check("wrap_nolink", {31'b0, link_we}, 32'h0);

        fetch_ack(32'h0000_0067);
        exec(1'b1, 32'h42, 1'b1, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
        check("align_fault", {31'b0, fault}, 32'h1);
        check("align_pc", pc, 32'h0);
        check("align_nolink", {31'b0, link_we}, 32'h0);
        pulse_start();
`else
        check("unaligned_fault", {31'b0, fault}, 32'h0);
        check("unaligned_pc", pc, 32'h42);
        check("unaligned_link", link_addr, 32'h4);
`endif
        check("pre_rst_req", {31'b0, imem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", {31'b0, imem_req}, 32'h0);
        check("async_rst_pc", pc, 32'h0);
        step();
        rst_n     = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 32'hBAD0_BAD0;
        step();
        imem_ack  = 1'b0;
        check("post_rst_ack_ivalid", {31'b0, instr_valid}, 32'h0);
        check("post_rst_ack_instr", instr, 32'h0);
        check("post_rst_idle_req", {31'b0, imem_req}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
